// File: rtl/lcd_char_ctrl.sv
// HD44780 character-LCD controller: frame buffer, power-up init, frame streaming.
// Ports: clk, rst (async, active high); wr_en/wr_addr/wr_data write one buffer byte;
//        refresh requests a frame; lcd_rs/lcd_rw/lcd_en/lcd_dat drive the panel;
//        init_done, busy and frame_done report status.
// Build option: define LCD_4BIT_EN for a 4-bit panel bus (nibbles on lcd_dat[7:4]).
module lcd_char_ctrl #(
    parameter int CLK_DIV     = 16,
    parameter int NUM_COLS    = 16,
    parameter int NUM_ROWS    = 2,
    parameter int PWRUP_TICKS = 1000,
    parameter int CLR_TICKS   = 100,
    localparam int DEPTH      = NUM_ROWS * NUM_COLS,
    localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              refresh,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_en,
    output logic [7:0]        lcd_dat,
    output logic              init_done,
    output logic              busy,
    output logic              frame_done
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic ROW_LAST = 1'(NUM_ROWS - 1);
`ifdef LCD_4BIT_EN
    localparam logic [7:0] FUNC_SET = 8'h28;
`else
    localparam logic [7:0] FUNC_SET = 8'h38;
`endif

    typedef enum logic [2:0] {
        S_PWRUP,
        S_PRE4,
        S_INIT,
        S_CLR_WAIT,
        S_IDLE,
        S_ROW_ADDR,
        S_CHARS,
        S_DONE
    } state_t;

    state_t            state_q, state_n;
    logic [DIV_W-1:0]  div_q;
    logic              tick;
    logic [1:0]        sub_q, sub_n;
    logic [1:0]        idx_q, idx_n;
    logic              row_q, row_n;
    logic [COL_W-1:0]  col_q, col_n;
    logic [31:0]       wcnt_q, wcnt_n;
    logic              dirty_q, pend_q;
    logic              start, wr_ok, byte_end;
    logic [7:0]        fb_q [DEPTH];
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        out_byte, bus_byte;
    logic              en_n, rs_n, done_n;
    logic [7:0]        dat_n;
`ifdef LCD_4BIT_EN
    logic              nib_q, nib_n;
`endif

    assign lcd_rw     = 1'b0;
    assign frame_done = (state_q == S_DONE);
    assign tick       = (div_q == DIV_W'(CLK_DIV - 1));
    assign wr_ok      = wr_en && (32'(wr_addr) < 32'(DEPTH));
    assign rd_addr    = ADDR_W'(32'(row_q) * 32'(NUM_COLS) + 32'(col_q));

    // Byte the current state wants on the bus
    always_comb begin
        out_byte = fb_q[rd_addr];
        unique case (state_q)
            S_INIT: begin
                unique case (idx_q)
                    2'd0:    out_byte = FUNC_SET;
                    2'd1:    out_byte = 8'h0C;
                    2'd2:    out_byte = 8'h06;
                    default: out_byte = 8'h01;
                endcase
            end
            S_ROW_ADDR: out_byte = row_q ? 8'hC0 : 8'h80;
`ifdef LCD_4BIT_EN
            S_PRE4:     out_byte = (idx_q == 2'd3) ? 8'h20 : 8'h30;
`endif
            default: ;
        endcase
    end

`ifdef LCD_4BIT_EN
    // Wake-up nibbles are single transfers; all other bytes take two
    assign bus_byte = {nib_q ? out_byte[3:0] : out_byte[7:4], 4'h0};
    assign byte_end = tick && (sub_q == 2'd2)
                      && (nib_q || state_q == S_PRE4);
`else
    assign bus_byte = out_byte;
    assign byte_end = tick && (sub_q == 2'd2);
`endif

    always_comb begin
        state_n = state_q;
        sub_n   = sub_q;
        idx_n   = idx_q;
        row_n   = row_q;
        col_n   = col_q;
        wcnt_n  = wcnt_q;
        en_n    = lcd_en;
        rs_n    = lcd_rs;
        dat_n   = lcd_dat;
        done_n  = init_done;
        start   = 1'b0;
`ifdef LCD_4BIT_EN
        nib_n   = nib_q;
`endif
        unique case (state_q)
            S_PWRUP: begin
                if (tick) begin
                    if (wcnt_q == 32'(PWRUP_TICKS - 1)) begin
                        wcnt_n = '0;
                        idx_n  = '0;
                        sub_n  = '0;
`ifdef LCD_4BIT_EN
                        state_n = S_PRE4;
`else
                        state_n = S_INIT;
`endif
                    end else begin
                        wcnt_n = wcnt_q + 32'd1;
                    end
                end
            end
            S_CLR_WAIT: begin
                if (tick) begin
                    if (wcnt_q == 32'(CLR_TICKS - 1)) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        wcnt_n = wcnt_q + 32'd1;
                    end
                end
            end
            S_IDLE: begin
                if (tick && (dirty_q || pend_q)) begin
                    start   = 1'b1;
                    row_n   = 1'b0;
                    col_n   = '0;
                    sub_n   = '0;
                    state_n = S_ROW_ADDR;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: begin
                if (tick) begin
                    unique case (sub_q)
                        2'd0: begin
                            en_n  = 1'b0;
                            rs_n  = (state_q == S_CHARS);
                            dat_n = bus_byte;
                            sub_n = 2'd1;
                        end
                        2'd1: begin
                            en_n  = 1'b1;
                            sub_n = 2'd2;
                        end
                        default: begin
                            en_n  = 1'b0;
                            sub_n = 2'd0;
`ifdef LCD_4BIT_EN
                            nib_n = ~byte_end;
`endif
                            if (byte_end) begin
                                unique case (state_q)
                                    S_PRE4: begin
                                        idx_n = idx_q + 2'd1;
                                        if (idx_q == 2'd3)
                                            state_n = S_INIT;
                                    end
                                    S_INIT: begin
                                        idx_n = idx_q + 2'd1;
                                        if (idx_q == 2'd3) begin
                                            wcnt_n  = '0;
                                            state_n = S_CLR_WAIT;
                                        end
                                    end
                                    S_ROW_ADDR: begin
                                        col_n   = '0;
                                        state_n = S_CHARS;
                                    end
                                    default: begin
                                        if (col_q == COL_W'(NUM_COLS - 1)) begin
                                            col_n = '0;
                                            if (row_q == ROW_LAST) begin
                                                state_n = S_DONE;
                                            end else begin
                                                row_n   = row_q + 1'b1;
                                                state_n = S_ROW_ADDR;
                                            end
                                        end else begin
                                            col_n = col_q + 1'b1;
                                        end
                                    end
                                endcase
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_PWRUP;
            div_q     <= '0;
            sub_q     <= '0;
            idx_q     <= '0;
            row_q     <= 1'b0;
            col_q     <= '0;
            wcnt_q    <= '0;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_dat   <= 8'h00;
            init_done <= 1'b0;
            busy      <= 1'b0;
`ifdef LCD_4BIT_EN
            nib_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            div_q     <= tick ? '0 : div_q + 1'b1;
            sub_q     <= sub_n;
            idx_q     <= idx_n;
            row_q     <= row_n;
            col_q     <= col_n;
            wcnt_q    <= wcnt_n;
            lcd_en    <= en_n;
            lcd_rs    <= rs_n;
            lcd_dat   <= dat_n;
            init_done <= done_n;
            busy      <= (state_n != S_IDLE);
`ifdef LCD_4BIT_EN
            nib_q     <= nib_n;
`endif
        end
    end

    // A write in the same cycle as a frame start keeps its dirty flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                fb_q[i] <= 8'h20;
            dirty_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            if (wr_ok)
                fb_q[wr_addr] <= wr_data;
            dirty_q <= wr_ok | (dirty_q & ~start);
            pend_q  <= refresh | (pend_q & ~start);
        end
    end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Directed bench for lcd_char_ctrl: init, frames, bounds, mid-frame write, reset.
// Works for the 8-bit build and, with LCD_4BIT_EN defined, the 4-bit build.
module tb_lcd_char_ctrl;

    localparam int CD = 2;
`ifdef LCD_4BIT_EN
    localparam int NPB = 2;
    localparam int PRE = 4;
    localparam logic [7:0] FSET = 8'h28;
    localparam logic [7:0] ZLO = 8'h00;
`else
    localparam int NPB = 1;
    localparam int PRE = 0;
    localparam logic [7:0] FSET = 8'h38;
    localparam logic [7:0] ZLO = 8'h20;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       refresh = 1'b0;
    logic       lcd_rs, lcd_rw, lcd_en, init_done, busy, frame_done;
    logic [7:0] lcd_dat;

    logic       b_wr_en = 1'b0;
    logic [1:0] b_wr_addr = '0;
    logic [7:0] b_wr_data = '0;
    logic       b_refresh = 1'b0;
    logic       b_lcd_rs, b_lcd_rw, b_lcd_en, b_init_done, b_busy, b_frame_done;
    logic [7:0] b_lcd_dat;

    always #5 clk = ~clk;

    lcd_char_ctrl #(
        .CLK_DIV(CD), .NUM_COLS(16), .NUM_ROWS(2),
        .PWRUP_TICKS(4), .CLR_TICKS(3)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .refresh(refresh), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat(lcd_dat),
        .init_done(init_done), .busy(busy), .frame_done(frame_done)
    );

    lcd_char_ctrl #(
        .CLK_DIV(CD), .NUM_COLS(3), .NUM_ROWS(1),
        .PWRUP_TICKS(2), .CLR_TICKS(1)
    ) dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .refresh(b_refresh), .lcd_rs(b_lcd_rs),
        .lcd_rw(b_lcd_rw), .lcd_en(b_lcd_en), .lcd_dat(b_lcd_dat),
        .init_done(b_init_done), .busy(b_busy), .frame_done(b_frame_done)
    );

    int passed = 0;
    int failed = 0;
    int total = 0;

    int cyc = 0;
    int rel_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main-panel monitor: one entry per enable strobe
    logic [8:0] raw[$];
    logic [8:0] hold;
    logic       en_prev = 1'b0;
    int         en_hi = 0;
    int         en_bad = 0;
    int         lo_bad = 0;
    int         fd_cnt = 0;
    int         first_rise = -1;
    int         last_fall = 0;
    logic       fd_seen = 1'b0;
    logic       busy_at_fd = 1'bx;
    logic       busy_after_fd = 1'bx;

    always @(negedge clk) begin
        if (rst) begin
            en_prev = 1'b0;
            en_hi = 0;
            first_rise = -1;
        end else begin
            if (lcd_en) begin
                en_hi++;
                hold = {lcd_rs, lcd_dat};
                if (!en_prev && first_rise < 0)
                    first_rise = cyc - rel_cyc;
            end else if (en_prev) begin
                raw.push_back(hold);
                if (en_hi != CD)
                    en_bad++;
                en_hi = 0;
                last_fall = cyc;
            end
`ifdef LCD_4BIT_EN
            if (lcd_dat[3:0] != 4'h0)
                lo_bad++;
`endif
            if (fd_seen) begin
                busy_after_fd = busy;
                fd_seen = 1'b0;
            end
            if (frame_done) begin
                fd_cnt++;
                busy_at_fd = busy;
                fd_seen = 1'b1;
            end
            en_prev = lcd_en;
        end
    end

    // Small-panel monitor: strobe and frame counts only
    int         b_str = 0;
    int         b_fd = 0;
    int         b_bad = 0;
    logic       b_prev = 1'b0;
    logic [8:0] b_hold;

    always @(negedge clk) begin
        if (rst) begin
            b_prev = 1'b0;
        end else begin
            if (b_lcd_en) begin
                b_hold = {b_lcd_rs, b_lcd_dat};
            end else if (b_prev) begin
                b_str++;
                if (b_hold[8] && b_hold[7:0] != 8'h20 && b_hold[7:0] != ZLO)
                    b_bad++;
            end
            if (b_frame_done)
                b_fd++;
            b_prev = b_lcd_en;
        end
    end

    logic [7:0] mem [32];
    logic [7:0] cmds [4];

    task automatic tk();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input int base);
        return (raw.size() - base) / NPB;
    endfunction

    function automatic logic [8:0] byte_at(input int base, input int i);
        logic [8:0] a;
        logic [8:0] b;
        a = raw[base + NPB * i];
        b = raw[base + NPB * i + NPB - 1];
`ifdef LCD_4BIT_EN
        return {a[8], a[7:4], b[7:4]};
`else
        if (b !== a)
            a = 9'bx;
        return a;
`endif
    endfunction

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tk();
        wr_en = 1'b0;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        tk();
        refresh = 1'b0;
    endtask

    task automatic wait_fd(input int target, input string tag);
        int n;
        n = 0;
        while (fd_cnt < target && n < 3000) begin
            tk();
            n++;
        end
        chk(tag, 32'(fd_cnt >= target), 1);
    endtask

    task automatic wait_init(input string tag, output int gap);
        int n;
        n = 0;
        while (!init_done && n < 500) begin
            tk();
            n++;
        end
        gap = cyc - last_fall;
        chk(tag, init_done, 1);
    endtask

    task automatic check_init(input int bb, input string tag);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_cmd%0d", tag, k), byte_at(bb, k), {1'b0, cmds[k]});
    endtask

    task automatic check_frame(input int bb, input int first, input string tag);
        logic [8:0] e;
        for (int k = 0; k < 34; k++) begin
            if (k == 0)
                e = 9'h080;
            else if (k < 17)
                e = {1'b1, mem[k - 1]};
            else if (k == 17)
                e = 9'h0C0;
            else
                e = {1'b1, mem[k - 2]};
            chk($sformatf("%s_b%0d", tag, k), byte_at(bb, first + k), e);
        end
    endtask

    initial begin
        string s;
        int    gap;
        int    n;
        int    bb;
        int    fd0;
        int    b0;
        int    bf0;

        s = "TEMP: 23.5C";
        cmds[0] = FSET;
        cmds[1] = 8'h0C;
        cmds[2] = 8'h06;
        cmds[3] = 8'h01;
        for (int i = 0; i < 32; i++)
            mem[i] = 8'h20;

        // Reset state
        repeat (3) tk();
        chk("rst_en", lcd_en, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_dat", lcd_dat, 8'h00);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rw_low", lcd_rw, 0);

        // Init sequence with text written while powering up
        rst = 1'b0;
        rel_cyc = cyc;
        bb = raw.size() + PRE;
        for (int i = 0; i < 11; i++) begin
            wr(5'(i), s[i]);
            mem[i] = s[i];
        end
        wait_init("init_to", gap);
        chk("pwrup_first_en", first_rise, 6 * CD);
        chk("clr_wait_gap", gap, 3 * CD);
        check_init(bb, "init");
`ifdef LCD_4BIT_EN
        chk("pre0", raw[0], 9'h030);
        chk("pre1", raw[1], 9'h030);
        chk("pre2", raw[2], 9'h030);
        chk("pre3", raw[3], 9'h020);
        chk("fset_hi", raw[4], 9'h020);
        chk("fset_lo", raw[5], 9'h080);
`endif

        // First frame from the dirty buffer
        wait_fd(1, "f1_to");
        tk();
        chk("busy_at_fd", busy_at_fd, 1);
        chk("busy_after_fd", busy_after_fd, 0);
        check_frame(bb, 4, "f1");
`ifdef LCD_4BIT_EN
        chk("t_hi", raw[bb + 10][7:4], 4'h5);
        chk("t_lo", raw[bb + 11][7:4], 4'h4);
`endif
        repeat (400) tk();
        chk("f1_bytes", nbytes(bb), 38);
        chk("f1_count", fd_cnt, 1);

        // Refresh with an unchanged buffer
        pulse_refresh();
        wait_fd(2, "f2_to");
        check_frame(bb, 38, "f2");
        repeat (400) tk();
        chk("f2_bytes", nbytes(bb), 72);

        // Write addr 2 after its byte went out in the running frame
        pulse_refresh();
        n = 0;
        while (nbytes(bb) < 76 && n < 1000) begin
            tk();
            n++;
        end
        chk("f3_progress", 32'(nbytes(bb) >= 76), 1);
        wr(5'd2, 8'h58);
        wait_fd(3, "f3_to");
        check_frame(bb, 72, "f3");
        mem[2] = 8'h58;
        wait_fd(4, "f4_to");
        check_frame(bb, 106, "f4");
        repeat (400) tk();
        chk("f4_bytes", nbytes(bb), 140);
        chk("f4_count", fd_cnt, 4);

        // Reset while enable is high inside a frame
        pulse_refresh();
        n = 0;
        while (!(lcd_en && nbytes(bb) > 140) && n < 1000) begin
            tk();
            n++;
        end
        chk("t1_reached", lcd_en, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_en", lcd_en, 0);
        chk("mid_rst_dat", lcd_dat, 8'h00);
        chk("mid_rst_init_done", init_done, 0);
        repeat (3) tk();
        for (int i = 0; i < 32; i++)
            mem[i] = 8'h20;
        rst = 1'b0;
        rel_cyc = cyc;
        bb = raw.size() + PRE;
        fd0 = fd_cnt;
        pulse_refresh();
        wait_init("init2_to", gap);
        chk("pwrup2_first_en", first_rise, 6 * CD);
        check_init(bb, "init2");
        wait_fd(fd0 + 1, "f5_to");
        check_frame(bb, 4, "f5");

        // Out-of-range write on the 1x3 panel
        chk("b_init_done", b_init_done, 1);
        b0 = b_str;
        bf0 = b_fd;
        b_wr_en = 1'b1;
        b_wr_addr = 2'd3;
        b_wr_data = 8'h5A;
        tk();
        b_wr_en = 1'b0;
        repeat (100) tk();
        chk("b_oob_no_frame", b_fd, bf0);
        chk("b_oob_no_bytes", b_str, b0);
        b_refresh = 1'b1;
        tk();
        b_refresh = 1'b0;
        n = 0;
        while (b_fd < bf0 + 1 && n < 500) begin
            tk();
            n++;
        end
        repeat (100) tk();
        chk("b_refresh_frames", b_fd, bf0 + 1);
        chk("b_refresh_bytes", b_str - b0, 4 * NPB);
        chk("b_chars_blank", b_bad, 0);
        chk("b_idle", b_busy, 0);
        chk("b_rw_low", b_lcd_rw, 0);

        chk("en_width", en_bad, 0);
`ifdef LCD_4BIT_EN
        chk("low_nibble_zero", lo_bad, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
